// File: rtl/din_pattern_checker.sv
// Ordered pattern-sequence checker for the din stimulus stream: detects P0->P1->P2->P3,
// pulses match/err and keeps saturating counts of completed and aborted sequences.
module din_pattern_checker #(
  parameter int             DW      = 6,
  parameter logic [DW-1:0]  P0      = 6'b011001,
  parameter logic [DW-1:0]  P1      = 6'b011011,
  parameter logic [DW-1:0]  P2      = 6'b011000,
  parameter logic [DW-1:0]  P3      = 6'b001000,
  parameter int             CNT_W   = 8,
  parameter int             TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  input  logic [DW-1:0]    din,
  input  logic             clr,
  output logic             match,
  output logic             err,
  output logic [1:0]       state_idx,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    EXP0 = 2'd0,
    EXP1 = 2'd1,
    EXP2 = 2'd2,
    EXP3 = 2'd3
  } state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [DW-1:0]   exp_pat;
  logic            hit;

  always_comb begin
    exp_pat = P0;
    unique case (state)
      EXP0: exp_pat = P0;
      EXP1: exp_pat = P1;
      EXP2: exp_pat = P2;
      EXP3: exp_pat = P3;
      default: exp_pat = P0;
    endcase
    hit = (din == exp_pat);
  end

  assign state_idx = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EXP0;
      timer     <= '0;
      match     <= 1'b0;
      err       <= 1'b0;
      match_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      match <= 1'b0;
      err   <= 1'b0;
      if (clr) begin
        state     <= EXP0;
        timer     <= '0;
        match_cnt <= '0;
        err_cnt   <= '0;
      end else if (din_valid) begin
        timer <= '0;
        if (hit) begin
          if (state == EXP3) begin
            state <= EXP0;
            match <= 1'b1;
            if (match_cnt != '1) match_cnt <= match_cnt + 1'b1;
          end else begin
            state <= state_t'(state + 2'd1);
          end
        end else if (state != EXP0) begin
          // A mismatching P0 is itself the start of a new sequence.
          state <= (din == P0) ? EXP1 : EXP0;
          err   <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
      end else if (state != EXP0) begin
        if (timer == TW'(TIMEOUT - 1)) begin
          state <= EXP0;
          timer <= '0;
          err   <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end else begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_din_pattern_checker.sv
// Directed bench for din_pattern_checker: a progress-index model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_din_pattern_checker;

  localparam int CW   = 2;
  localparam int TO   = 16;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          din_valid;
  logic [5:0]    din;
  logic          clr;
  logic          match;
  logic          err;
  logic [1:0]    state_idx;
  logic [CW-1:0] match_cnt;
  logic [CW-1:0] err_cnt;

  int n_vec = 0;
  int n_err = 0;
  int match_seen = 0;

  logic [5:0] pat [4] = '{6'b011001, 6'b011011, 6'b011000, 6'b001000};

  din_pattern_checker #(
    .DW(6), .P0(6'b011001), .P1(6'b011011), .P2(6'b011000), .P3(6'b001000),
    .CNT_W(CW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clr(clr),
    .match(match), .err(err), .state_idx(state_idx),
    .match_cnt(match_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Model: progress = number of patterns already matched, plus idle count and tallies.
  int m_prog, m_idle, m_mc, m_ec;
  bit m_match, m_err;

  always @(posedge clk or negedge rst_n) begin : model
    int p, i, mc, ec;
    bit mm, me;
    if (!rst_n) begin
      m_prog <= 0; m_idle <= 0; m_mc <= 0; m_ec <= 0; m_match <= 0; m_err <= 0;
    end else begin
      p = m_prog; i = m_idle; mc = m_mc; ec = m_ec; mm = 0; me = 0;
      if (clr) begin
        p = 0; i = 0; mc = 0; ec = 0;
      end else if (din_valid) begin
        i = 0;
        if (din == pat[p]) begin
          if (p == 3) begin p = 0; mm = 1; mc = (mc < MAXC) ? mc + 1 : MAXC; end
          else p = p + 1;
        end else if (p != 0) begin
          me = 1; ec = (ec < MAXC) ? ec + 1 : MAXC;
          p = (din == pat[0]) ? 1 : 0;
        end
      end else if (p != 0) begin
        i = i + 1;
        if (i == TO) begin p = 0; i = 0; me = 1; ec = (ec < MAXC) ? ec + 1 : MAXC; end
      end
      m_prog <= p; m_idle <= i; m_mc <= mc; m_ec <= ec; m_match <= mm; m_err <= me;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_match", int'(match), int'(m_match));
    chk("cyc_err", int'(err), int'(m_err));
    chk("cyc_state", int'(state_idx), m_prog);
    chk("cyc_match_cnt", int'(match_cnt), m_mc);
    chk("cyc_err_cnt", int'(err_cnt), m_ec);
    if (match === 1'b1) match_seen++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [5:0] d);
    din_valid = 1'b1;
    din = d;
    step();
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    din = 'x;
    repeat (n) step();
  endtask

  task automatic do_reset();
    din_valid = 1'b0;
    din = '0;
    clr = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic full_seq();
    for (int k = 0; k < 4; k++) send(pat[k]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; din_valid = 1'b0; din = '0; clr = 1'b0;
    do_reset();
    chk("rst_match", int'(match), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_state", int'(state_idx), 0);
    chk("rst_match_cnt", int'(match_cnt), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);

    // Leading idle data then a clean sequence.
    send(6'b000000);
    chk("lead_state", int'(state_idx), 0);
    chk("lead_err", int'(err), 0);
    full_seq();
    chk("seq1_match", int'(match), 1);
    chk("seq1_match_cnt", int'(match_cnt), 1);
    chk("seq1_state", int'(state_idx), 0);
    chk("seq1_err_cnt", int'(err_cnt), 0);
    idle(1);
    chk("seq1_match_drop", int'(match), 0);

    // Mismatch with P0 overlap restart.
    do_reset();
    send(pat[0]); send(pat[1]); send(pat[0]);
    chk("ovl_err", int'(err), 1);
    chk("ovl_state", int'(state_idx), 1);
    chk("ovl_err_cnt", int'(err_cnt), 1);
    send(pat[1]); send(pat[2]); send(pat[3]);
    chk("ovl_match", int'(match), 1);
    chk("ovl_err_low", int'(err), 0);
    chk("ovl_match_cnt", int'(match_cnt), 1);
    chk("ovl_err_cnt2", int'(err_cnt), 1);

    // Idle timeout after exactly TIMEOUT idle cycles.
    do_reset();
    send(pat[0]);
    idle(TO - 1);
    chk("to15_err", int'(err), 0);
    chk("to15_state", int'(state_idx), 1);
    idle(1);
    chk("to16_err", int'(err), 1);
    chk("to16_state", int'(state_idx), 0);
    chk("to16_err_cnt", int'(err_cnt), 1);
    do_reset();
    send(pat[0]);
    idle(TO - 1);
    send(pat[1]);
    chk("to_noerr", int'(err), 0);
    chk("to_state2", int'(state_idx), 2);
    chk("to_err_cnt0", int'(err_cnt), 0);

    // Counter saturation.
    do_reset();
    match_seen = 0;
    for (int s = 0; s < 5; s++) full_seq();
    idle(1);
    chk("sat_match_cnt", int'(match_cnt), MAXC);
    chk("sat_pulses", match_seen, 5);
    for (int s = 0; s < 5; s++) begin send(pat[0]); send(6'b000000); end
    chk("sat_err_cnt", int'(err_cnt), MAXC);

    // Asynchronous reset mid-sequence.
    do_reset();
    send(pat[0]); send(pat[1]);
    chk("pre_arst_state", int'(state_idx), 2);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_state", int'(state_idx), 0);
    chk("arst_match", int'(match), 0);
    chk("arst_err", int'(err), 0);
    chk("arst_err_cnt", int'(err_cnt), 0);
    din_valid = 1'b0;
    step();
    rst_n = 1'b1;
    send(pat[1]);
    chk("post_arst_state", int'(state_idx), 0);
    chk("post_arst_err_cnt", int'(err_cnt), 0);

    // Synchronous clear beats a valid P0 sample.
    do_reset();
    full_seq(); full_seq();
    send(pat[0]); send(6'b111111);
    chk("pre_clr_match_cnt", int'(match_cnt), 2);
    chk("pre_clr_err_cnt", int'(err_cnt), 1);
    clr = 1'b1;
    send(pat[0]);
    clr = 1'b0;
    chk("clr_match_cnt", int'(match_cnt), 0);
    chk("clr_err_cnt", int'(err_cnt), 0);
    chk("clr_state", int'(state_idx), 0);
    chk("clr_err", int'(err), 0);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/din_pattern_checker.md
Name: din_pattern_checker

Overview:
- Sequential checker that consumes the 6-bit `din` stimulus stream produced by the vector-generation stage and detects the ordered pattern sequence P0→P1→P2→P3.
- Reports each complete sequence with a pulse and a counter.
- Flags broken partial sequences and inactivity timeouts.
- Sits directly downstream of the stimulus source; its status is used for self-checking benches and on-chip loopback tests.

Parameters:
- DW, 6, data width of din.
- P0, 6'b011001, first expected pattern.
- P1, 6'b011011, second expected pattern.
- P2, 6'b011000, third expected pattern.
- P3, 6'b001000, last expected pattern.
- CNT_W, 8, width of the match and error counters.
- TIMEOUT, 16, max idle cycles (din_valid low) allowed inside a partial sequence; must be ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din_valid  input  1  din is sampled on a rising clk edge only when high.
- din  input  DW  pattern data from the upstream generator.
- clr  input  1  synchronous clear of both counters and the FSM; takes priority over din_valid.
- match  output  1  one-cycle pulse: full P0..P3 sequence completed.
- err  output  1  one-cycle pulse: partial sequence aborted (mismatch or timeout).
- state_idx  output  2  current FSM state encoding (0..3).
- match_cnt  output  CNT_W  number of completed sequences, saturating.
- err_cnt  output  CNT_W  number of aborted sequences, saturating.

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low (rst_n); all state registers reset on rst_n low regardless of clk.
- Reset values: match=0, err=0, state_idx=0 (EXP0), match_cnt=0, err_cnt=0, idle timer=0.
- FSM states:
  - EXP0 (0): awaiting P0.
  - EXP1 (1): awaiting P1.
  - EXP2 (2): awaiting P2.
  - EXP3 (3): awaiting P3.
- Transitions on a cycle with din_valid=1 and clr=0:
  - din equals expected pattern of EXP0/EXP1/EXP2 → advance to the next state; no pulse.
  - In EXP3 with din==P3 → go to EXP0; match=1 next cycle; match_cnt+1.
  - In EXP0 with din≠P0 → stay in EXP0; no err (leading/idle data such as 6'b000000 is ignored).
  - In EXP1..EXP3 with a mismatch → err=1 next cycle; err_cnt+1. Next state is EXP1 if din==P0 (restart overlap), else EXP0.
- din_valid=0:
  - State holds.
  - Idle timer increments only while state≠EXP0.
  - When the timer reaches TIMEOUT → state to EXP0, err pulse, err_cnt+1, timer cleared.
- Idle timer clears on any valid sample and on entry to EXP0.
- Latency: match and err are registered and appear exactly one cycle after the sampling edge of the deciding din. They are never high in the same cycle and are low in all other cycles.
- Saturation: counters stop at 2^CNT_W−1 and never wrap.
- clr=1:
  - Next cycle counters=0, state=EXP0, timer=0, match=err=0.
  - The din sample in that cycle is discarded.
- Reset mid-sequence: asynchronous return to reset values; the partial sequence is not counted as an error.
- Data X/Z with din_valid=0 must not affect state.

Test Plan:
- Reset, then valid din 000000, 011001, 011011, 011000, 001000 on consecutive cycles → match pulses 1 cycle after the 001000 edge; match_cnt=1; err never set; state_idx back to 0.
- Sequence 011001, 011011, 011001, 011011, 011000, 001000 → one err pulse after the third sample (state goes to 1 via overlap); then match; err_cnt=1, match_cnt=1.
- 011001, then din_valid low for 16 cycles (TIMEOUT=16) → err pulse on the 16th idle cycle; state_idx=0; err_cnt=1. With 15 idle cycles followed by 011011 → no err, state_idx=2.
- With CNT_W=2, drive 5 full sequences → match_cnt saturates at 3; match pulses 5 times.
- Drive 011001, 011011, then assert rst_n=0 asynchronously between clk edges → all outputs 0 immediately; after release, err_cnt=0 and 011011 alone does not advance the FSM.
- match_cnt=2, err_cnt=1, then clr=1 together with din_valid=1 and din=011001 → next cycle counters=0 and state_idx=0 (sample ignored).
